ntt_coeff_loader: RTL and testbench

- Upstream feeder for the parallel NTT/INTT processing unit.
- Accepts one N-bit coefficient per cycle over a valid/ready stream and reduces each into [0, Q).
- Assembles D coefficients into a ping-pong frame buffer, then presents a full D*N frame, a per-frame inv flag and a start pulse to the processing unit.
- Holds the frame stable for HOLD_CYCLES while the unit runs its stages; the next frame fills concurrently.

---
 rtl/ntt_coeff_loader_pkg.sv | 34 +++
 rtl/ntt_mod_reduce_single.sv | 39 +++
 rtl/ntt_coeff_loader.sv | 225 ++++++++++++++++++++++
 tb/tb_ntt_coeff_loader.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_coeff_loader_pkg.sv
// Shared definitions for the NTT front end: default sizing, the modulus and
// its inverse-size constant, FSM state encodings, and the bit-reverse index
// helper shared with the twiddle factor generator.
package ntt_coeff_loader_pkg;

  localparam int unsigned NTT_N    = 17;     // coefficient width in bits
  localparam int unsigned NTT_D    = 16;     // coefficients per frame
  localparam int unsigned NTT_Q    = 65537;  // modulus, 2^N < 2*Q
  localparam int unsigned NTT_NINV = 61441;  // D^-1 mod Q for D = 16

  // Fill side: collecting coefficients, or holding a complete frame.
  typedef enum logic [0:0] {
    FILL_S = 1'b0,
    FULL_S = 1'b1
  } fill_state_e;

  // Hold side: no frame presented, or a frame held for the unit.
  typedef enum logic [0:0] {
    IDLE_S = 1'b0,
    HOLD_S = 1'b1
  } hold_state_e;

  // Reverse the low nbits of k (k = 1 with nbits = 4 gives 8).
  function automatic int unsigned bitrev_idx(input int unsigned k,
                                             input int unsigned nbits);
    int unsigned r;
    r = 32'd0;
    for (int unsigned b = 32'd0; b < nbits; b++) begin
      r = (r << 1) | ((k >> b) & 32'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/ntt_mod_reduce_single.sv
// Single conditional subtraction of Q. Valid for any input below 2*Q, which
// covers every N-bit value when 2^N < 2*Q. Purely combinational.
module ntt_mod_reduce_single
  import ntt_coeff_loader_pkg::*;
#(
  parameter int unsigned N = NTT_N,
  parameter int unsigned Q = NTT_Q
) (
  input  logic [N-1:0] i_x,
  output logic [N-1:0] o_y
);

  localparam logic [N:0] Q_EXT = (N+1)'(Q);

  logic [N:0] w_ext;
  logic [N:0] w_diff;
  logic       w_ge;
  logic [N:0] w_sel;
  logic       w_unused_msb;

  assign w_ext  = {1'b0, i_x};
  assign w_ge   = (w_ext >= Q_EXT);
  assign w_diff = w_ext - Q_EXT;

  // Pick the subtracted value only when the input reaches the modulus.
  always_comb begin
    w_sel = w_ext;
    if (w_ge) begin
      w_sel = w_diff;
    end else begin
      w_sel = w_ext;
    end
  end

  // The result is always below Q and fits in N bits; the top bit is dropped.
  assign o_y          = w_sel[N-1:0];
  assign w_unused_msb = w_sel[N];

endmodule

// File: rtl/ntt_coeff_loader.sv
// Coefficient loader for the parallel NTT/INTT unit.
// Reduces streamed coefficients into [0, Q), assembles D of them into a fill
// bank and swaps the complete bank onto the unit's frame bus, where it is
// held for HOLD_CYCLES while the next frame fills.
// Build option: define NTT_LOADER_BITREV_EN to store coefficient k in lane
// bitrev(k) instead of lane k; handshake and timing are unchanged.
module ntt_coeff_loader
  import ntt_coeff_loader_pkg::*;
#(
  parameter int unsigned N           = NTT_N,
  parameter int unsigned D           = NTT_D,
  parameter int unsigned Q           = NTT_Q,
  parameter int unsigned HOLD_CYCLES = $clog2(D)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [N-1:0]   in_data,
  input  logic           in_inv,
  output logic           in_ready,
  output logic [D*N-1:0] pu_a,
  output logic           pu_inv,
  output logic           pu_start,
  output logic           pu_busy,
  output logic           frame_done
);

  localparam int unsigned LOG2D = $clog2(D);
  localparam int unsigned CW    = LOG2D + 1;
  localparam int unsigned HW    = $clog2(HOLD_CYCLES + 1);

  localparam logic [CW-1:0] D_CNT    = CW'(D);
  localparam logic [CW-1:0] D_LAST   = CW'(D - 1);
  localparam logic [HW-1:0] HOLD_LD  = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);

  // Fill side state
  fill_state_e     r_fill_state;
  fill_state_e     w_fill_state_nxt;
  logic [CW-1:0]   r_fill_cnt;
  logic [CW-1:0]   w_fill_cnt_nxt;
  logic            r_fill_inv;
  logic [N-1:0]    r_bank [0:D-1];

  // Hold side state
  hold_state_e     r_hold_state;
  hold_state_e     w_hold_state_nxt;
  logic [HW-1:0]   r_hold_cnt;
  logic [HW-1:0]   w_hold_cnt_nxt;

  // Presented frame
  logic [D*N-1:0]  r_pu_a;
  logic            r_pu_inv;
  logic            r_pu_start;

  // Datapath
  logic            w_xfer;
  logic            w_swap;
  logic [N-1:0]    w_red;
  logic [LOG2D-1:0] w_lane;
  logic [D*N-1:0]  w_bank_flat;

  ntt_mod_reduce_single #(
    .N (N),
    .Q (Q)
  ) u_reduce (
    .i_x (in_data),
    .o_y (w_red)
  );

  // Ready depends only on the registered fill count, never on in_valid.
  assign in_ready = (r_fill_cnt != D_CNT);
  assign w_xfer   = in_valid && in_ready;

  // A full bank moves out when the hold side is idle or in its last cycle.
  assign w_swap = (r_fill_cnt == D_CNT) &&
                  ((r_hold_cnt == '0) || (r_hold_cnt == HOLD_ONE));

  // Lane chosen for the coefficient being written this cycle.
  always_comb begin
    w_lane = '0;
`ifdef NTT_LOADER_BITREV_EN
    w_lane = LOG2D'(bitrev_idx(32'(r_fill_cnt[LOG2D-1:0]), LOG2D));
`else
    w_lane = r_fill_cnt[LOG2D-1:0];
`endif
  end

  // Fill side next state: count transfers up to D, clear on swap.
  always_comb begin
    w_fill_state_nxt = r_fill_state;
    w_fill_cnt_nxt   = r_fill_cnt;
    case (r_fill_state)
      FILL_S: begin
        if (w_xfer) begin
          w_fill_cnt_nxt = r_fill_cnt + CW'(1);
          if (r_fill_cnt == D_LAST) begin
            w_fill_state_nxt = FULL_S;
          end else begin
            w_fill_state_nxt = FILL_S;
          end
        end else begin
          w_fill_state_nxt = FILL_S;
        end
      end
      FULL_S: begin
        if (w_swap) begin
          w_fill_state_nxt = FILL_S;
          w_fill_cnt_nxt   = '0;
        end else begin
          w_fill_state_nxt = FULL_S;
        end
      end
      default: begin
        w_fill_state_nxt = FILL_S;
        w_fill_cnt_nxt   = '0;
      end
    endcase
  end

  // Hold side next state: load on swap, count down to idle otherwise.
  always_comb begin
    w_hold_state_nxt = r_hold_state;
    w_hold_cnt_nxt   = r_hold_cnt;
    case (r_hold_state)
      IDLE_S: begin
        if (w_swap) begin
          w_hold_state_nxt = HOLD_S;
          w_hold_cnt_nxt   = HOLD_LD;
        end else begin
          w_hold_state_nxt = IDLE_S;
          w_hold_cnt_nxt   = '0;
        end
      end
      HOLD_S: begin
        if (w_swap) begin
          w_hold_state_nxt = HOLD_S;
          w_hold_cnt_nxt   = HOLD_LD;
        end else if (r_hold_cnt == HOLD_ONE) begin
          w_hold_state_nxt = IDLE_S;
          w_hold_cnt_nxt   = '0;
        end else begin
          w_hold_state_nxt = HOLD_S;
          w_hold_cnt_nxt   = r_hold_cnt - HOLD_ONE;
        end
      end
      default: begin
        w_hold_state_nxt = IDLE_S;
        w_hold_cnt_nxt   = '0;
      end
    endcase
  end

  // State and counter registers for both sides.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fill_state <= FILL_S;
      r_fill_cnt   <= '0;
      r_hold_state <= IDLE_S;
      r_hold_cnt   <= '0;
    end else begin
      r_fill_state <= w_fill_state_nxt;
      r_fill_cnt   <= w_fill_cnt_nxt;
      r_hold_state <= w_hold_state_nxt;
      r_hold_cnt   <= w_hold_cnt_nxt;
    end
  end

  // Frame direction is taken from the first coefficient of each frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fill_inv <= 1'b0;
    end else if (w_xfer && (r_fill_cnt == '0)) begin
      r_fill_inv <= in_inv;
    end else begin
      r_fill_inv <= r_fill_inv;
    end
  end

  // Fill bank write; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < D; k++) begin
        r_bank[k] <= '0;
      end
    end else if (w_xfer) begin
      r_bank[w_lane] <= w_red;
    end else begin
      r_bank[w_lane] <= r_bank[w_lane];
    end
  end

  // Pack the fill bank into the frame bus layout, lane k at [N*(k+1)-1:N*k].
  always_comb begin
    w_bank_flat = '0;
    for (int k = 0; k < D; k++) begin
      w_bank_flat[N*k +: N] = r_bank[k];
    end
  end

  // Presented frame registers: captured on swap, kept afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pu_a     <= '0;
      r_pu_inv   <= 1'b0;
      r_pu_start <= 1'b0;
    end else begin
      r_pu_start <= w_swap;
      if (w_swap) begin
        r_pu_a   <= w_bank_flat;
        r_pu_inv <= r_fill_inv;
      end else begin
        r_pu_a   <= r_pu_a;
        r_pu_inv <= r_pu_inv;
      end
    end
  end

  assign pu_a       = r_pu_a;
  assign pu_inv     = r_pu_inv;
  assign pu_start   = r_pu_start;
  assign pu_busy    = (r_hold_cnt != '0);
  assign frame_done = (r_hold_cnt == HOLD_ONE);

endmodule

// File: tb/tb_ntt_coeff_loader.sv
// Directed self-checking bench for ntt_coeff_loader (N=17, D=16, Q=65537).
// Lane expectations follow NTT_LOADER_BITREV_EN when it is defined.
module tb_ntt_coeff_loader;

  localparam int N     = 17;
  localparam int D     = 16;
  localparam int LOG2D = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic [N-1:0]   in_data;
  logic           in_inv;
  logic           in_ready;
  logic [D*N-1:0] pu_a;
  logic           pu_inv;
  logic           pu_start;
  logic           pu_busy;
  logic           frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [N-1:0] exp_v [D];

  always #5 clk = ~clk;

  ntt_coeff_loader dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_inv     (in_inv),
    .in_ready   (in_ready),
    .pu_a       (pu_a),
    .pu_inv     (pu_inv),
    .pu_start   (pu_start),
    .pu_busy    (pu_busy),
    .frame_done (frame_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lane_of(input int k);
    int r = 0;
`ifdef NTT_LOADER_BITREV_EN
    for (int b = 0; b < LOG2D; b++) r = (r << 1) | ((k >> b) & 1);
`else
    r = k;
`endif
    return r;
  endfunction

  // Expected frame bus: transfer k's expected value lands in lane_of(k).
  function automatic logic [D*N-1:0] exp_frame();
    logic [D*N-1:0] f = '0;
    for (int k = 0; k < D; k++) f[N*lane_of(k) +: N] = exp_v[k];
    return f;
  endfunction

  task automatic send(input int v, input logic inv);
    in_valid = 1'b1;
    in_data  = N'(v);
    in_inv   = inv;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 17'd9; in_inv = 1'b1;
    tick(); tick();
    rst = 1'b0; in_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (pu_a !== '0) begin n_fail++; $display("FAIL reset_pu_a: got %h expected 0", pu_a); end
    n_checks++; if (pu_inv !== 1'b0) begin n_fail++; $display("FAIL reset_pu_inv: got %b expected 0", pu_inv); end
    n_checks++; if (pu_start !== 1'b0) begin n_fail++; $display("FAIL reset_pu_start: got %b expected 0", pu_start); end
    n_checks++; if (pu_busy !== 1'b0) begin n_fail++; $display("FAIL reset_pu_busy: got %b expected 0", pu_busy); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after: got %b expected 1", in_ready); end
  endtask

  task automatic test_basic_frame();
    logic [4:0] start_exp = 5'b00001;
    logic [4:0] busy_exp  = 5'b01111;
    logic [4:0] done_exp  = 5'b01000;
    for (int k = 0; k < D; k++) exp_v[k] = N'(k);
    for (int k = 0; k < D; k++) send(k, 1'b0);
    in_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_full_ready: got %b expected 0", in_ready); end
    n_checks++; if (pu_start !== 1'b0) begin n_fail++; $display("FAIL basic_start_early: got %b expected 0", pu_start); end
    tick();
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (pu_start !== start_exp[i]) begin n_fail++; $display("FAIL basic_start cyc%0d: got %b expected %b", i, pu_start, start_exp[i]); end
      n_checks++; if (pu_busy !== busy_exp[i]) begin n_fail++; $display("FAIL basic_busy cyc%0d: got %b expected %b", i, pu_busy, busy_exp[i]); end
      n_checks++; if (frame_done !== done_exp[i]) begin n_fail++; $display("FAIL basic_done cyc%0d: got %b expected %b", i, frame_done, done_exp[i]); end
      n_checks++; if (pu_a !== exp_frame()) begin n_fail++; $display("FAIL basic_frame cyc%0d: got %h expected %h", i, pu_a, exp_frame()); end
      n_checks++; if (pu_inv !== 1'b0) begin n_fail++; $display("FAIL basic_inv cyc%0d: got %b expected 0", i, pu_inv); end
      tick();
    end
  endtask

  task automatic test_reduction();
    int in_v [D];
    in_v  = '{65536, 65537, 65538, 131071, 0, 65535, 100000, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    exp_v = '{17'd65536, 17'd0, 17'd1, 17'd65534, 17'd0, 17'd65535, 17'd34463, 17'd7,
              17'd8, 17'd9, 17'd10, 17'd11, 17'd12, 17'd13, 17'd14, 17'd15};
    for (int k = 0; k < D; k++) send(in_v[k], 1'b0);
    in_valid = 1'b0;
    for (int i = 0; i < 8 && pu_start !== 1'b1; i++) tick();
    n_checks++; if (pu_start !== 1'b1) begin n_fail++; $display("FAIL reduce_start: got %b expected 1", pu_start); end
    n_checks++; if (pu_a !== exp_frame()) begin n_fail++; $display("FAIL reduce_frame: got %h expected %h", pu_a, exp_frame()); end
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_back_to_back();
    int idx = 0, lows = 0, starts = 0, c1 = -1, c2 = -1;
    logic inv1 = 1'bx, inv2 = 1'bx;
    logic [D*N-1:0] fa = '0, fb = '0;
    for (int c = 0; c < 60; c++) begin
      if (pu_start === 1'b1) begin
        if (starts == 0) begin c1 = c; inv1 = pu_inv; fa = pu_a; end
        else if (starts == 1) begin c2 = c; inv2 = pu_inv; fb = pu_a; end
        starts++;
      end
      if (in_ready !== 1'b1) lows++;
      if (idx < 2*D) begin
        in_valid = 1'b1;
        in_data  = (idx < D) ? N'(200 + idx) : N'(300 + idx - D);
        // Frame A has inv=1 on every coefficient except index 0; frame B only on index 0.
        in_inv   = (idx == D) || (idx > 0 && idx < D);
        if (in_ready === 1'b1) idx++;
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    in_valid = 1'b0;
    n_checks++; if (starts != 2) begin n_fail++; $display("FAIL b2b_start_count: got %0d expected 2", starts); end
    n_checks++; if (lows != 2) begin n_fail++; $display("FAIL b2b_ready_low: got %0d expected 2", lows); end
    n_checks++; if (c2 - c1 != 17) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected 17", c2 - c1); end
    n_checks++; if (inv1 !== 1'b0) begin n_fail++; $display("FAIL b2b_inv_first: got %b expected 0", inv1); end
    n_checks++; if (inv2 !== 1'b1) begin n_fail++; $display("FAIL b2b_inv_second: got %b expected 1", inv2); end
    for (int k = 0; k < D; k++) exp_v[k] = N'(200 + k);
    n_checks++; if (fa !== exp_frame()) begin n_fail++; $display("FAIL b2b_frame_a: got %h expected %h", fa, exp_frame()); end
    for (int k = 0; k < D; k++) exp_v[k] = N'(300 + k);
    n_checks++; if (fb !== exp_frame()) begin n_fail++; $display("FAIL b2b_frame_b: got %h expected %h", fb, exp_frame()); end
  endtask

  task automatic test_stall();
    int bad = 0;
    for (int k = 0; k < D; k++) exp_v[k] = N'(400 + k);
    for (int k = 0; k < D; k++) begin
      if (k == 8) begin
        in_valid = 1'b0; in_data = 17'h1ffff; in_inv = 1'b1;
        for (int s = 0; s < 5; s++) begin
          tick();
          if (in_ready !== 1'b1 || pu_start !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL stall_held: got %0d bad cycles expected 0", bad); end
      end
      if (k == D - 1) begin
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready_15: got %b expected 1", in_ready); end
      end
      send(400 + k, 1'b0);
    end
    in_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready_16: got %b expected 0", in_ready); end
    tick();
    n_checks++; if (pu_start !== 1'b1) begin n_fail++; $display("FAIL stall_start: got %b expected 1", pu_start); end
    n_checks++; if (pu_a !== exp_frame()) begin n_fail++; $display("FAIL stall_frame: got %h expected %h", pu_a, exp_frame()); end
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_reset_mid_fill();
    for (int k = 0; k < 7; k++) send(900 + k, 1'b1);
    rst = 1'b1; in_valid = 1'b1; in_data = 17'd1234;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    n_checks++; if (pu_a !== '0) begin n_fail++; $display("FAIL midfill_pu_a: got %h expected 0", pu_a); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midfill_ready: got %b expected 1", in_ready); end
    for (int k = 0; k < D; k++) exp_v[k] = 17'd5;
    for (int k = 0; k < D; k++) send(5, 1'b0);
    in_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL midfill_full: got %b expected 0", in_ready); end
    tick();
    n_checks++; if (pu_start !== 1'b1) begin n_fail++; $display("FAIL midfill_start: got %b expected 1", pu_start); end
    n_checks++; if (pu_a !== exp_frame()) begin n_fail++; $display("FAIL midfill_frame: got %h expected %h", pu_a, exp_frame()); end
    n_checks++; if (pu_inv !== 1'b0) begin n_fail++; $display("FAIL midfill_inv: got %b expected 0", pu_inv); end
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_reset_in_hold();
    int seen = 0;
    for (int k = 0; k < D; k++) send(600 + k, (k == 0));
    in_valid = 1'b0;
    tick();
    n_checks++; if (pu_start !== 1'b1) begin n_fail++; $display("FAIL hold_start: got %b expected 1", pu_start); end
    n_checks++; if (pu_inv !== 1'b1) begin n_fail++; $display("FAIL hold_inv: got %b expected 1", pu_inv); end
    tick(); tick();
    n_checks++; if (pu_busy !== 1'b1 || frame_done !== 1'b0) begin n_fail++; $display("FAIL hold_cnt2: got busy=%b done=%b expected busy=1 done=0", pu_busy, frame_done); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (pu_busy !== 1'b0) begin n_fail++; $display("FAIL hold_rst_busy: got %b expected 0", pu_busy); end
    n_checks++; if (pu_a !== '0) begin n_fail++; $display("FAIL hold_rst_pu_a: got %h expected 0", pu_a); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL hold_rst_done: got %b expected 0", frame_done); end
    n_checks++; if (pu_inv !== 1'b0) begin n_fail++; $display("FAIL hold_rst_inv: got %b expected 0", pu_inv); end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (frame_done !== 1'b0 || pu_busy !== 1'b0 || pu_start !== 1'b0) seen++;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL hold_rst_quiet: got %0d active cycles expected 0", seen); end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_inv = 1'b0;
    #2;
    test_reset();
    test_basic_frame();
    test_reduction();
    test_back_to_back();
    test_stall();
    test_reset_mid_fill();
    test_reset_in_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected the test sequence to complete");
    $fatal(1, "watchdog expired");
  end

endmodule
